// File: rtl/imm_ext_pkg.sv
// Shared types for the immediate-extension pipe: extension modes and mode width.
package imm_ext_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    ZERO   = 2'd0,
    SIGN   = 2'd1,
    UPPER  = 2'd2,
    BRANCH = 2'd3
  } imm_mode_e;

endpackage

// File: rtl/imm_ext_fifo.sv
// Small circular buffer holding extended immediates (plus tag when enabled).
module imm_ext_fifo #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CntW  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic [W-1:0]    wdata_i,
  input  logic            pop_i,
  output logic            valid_o,
  output logic [W-1:0]    rdata_o,
  output logic [CntW-1:0] count_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]    mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Flush overrides both push and pop for the cycle.
  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && valid_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      count_d = count_q + CntW'(1);
      else if (!do_push && do_pop) count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign valid_o = (count_q != '0);
  // Gate the head so the output reads zero whenever the buffer is empty.
  assign rdata_o = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/imm_extend_pipe.sv
// Immediate extender (zero/sign/upper/branch) feeding a DEPTH-entry output buffer.
// Define IMM_EXT_TAG_EN to carry a TAG_W-bit sideband tag alongside each immediate.
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int unsigned IMM_W       = 7,
  parameter int unsigned OUT_W       = 16,
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned UPPER_SHAMT = 9,
  parameter int unsigned TAG_W       = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [IMM_W-1:0]             in_imm,
  input  logic [MODE_W-1:0]            in_mode,
`ifdef IMM_EXT_TAG_EN
  input  logic [TAG_W-1:0]             in_tag,
`endif
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_W-1:0]             out_imm,
`ifdef IMM_EXT_TAG_EN
  output logic [TAG_W-1:0]             out_tag,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
`ifdef IMM_EXT_TAG_EN
  localparam int unsigned EntryW = OUT_W + TAG_W;
`else
  localparam int unsigned EntryW = OUT_W;
`endif

  logic              ready_q;
  logic [OUT_W-1:0]  ext_zero, ext_sign, ext_imm;
  logic [EntryW-1:0] wdata, rdata;
  logic              push;

  assign ext_zero = OUT_W'(in_imm);
  assign ext_sign = OUT_W'($signed(in_imm));

  always_comb begin
    ext_imm = ext_zero;
    unique case (imm_mode_e'(in_mode))
      ZERO:   ext_imm = ext_zero;
      SIGN:   ext_imm = ext_sign;
      UPPER:  ext_imm = ext_zero << UPPER_SHAMT;
      BRANCH: ext_imm = ext_sign << 1;
    endcase
  end

  // Holds in_ready low during reset and until the first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ready_q <= 1'b0;
    else     ready_q <= 1'b1;
  end

  assign in_ready = ready_q && (count != CntW'(DEPTH)) && !flush;
  assign push     = in_valid && in_ready;

`ifdef IMM_EXT_TAG_EN
  assign wdata   = {in_tag, ext_imm};
  assign out_tag = rdata[EntryW-1 -: TAG_W];
`else
  assign wdata   = ext_imm;
`endif
  assign out_imm = rdata[OUT_W-1:0];

  imm_ext_fifo #(
    .W    (EntryW),
    .DEPTH(DEPTH),
    .CntW (CntW)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .flush_i(flush),
    .push_i (push),
    .wdata_i(wdata),
    .pop_i  (out_ready),
    .valid_o(out_valid),
    .rdata_o(rdata),
    .count_o(count)
  );

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe in its default (untagged) build.
module tb_imm_extend_pipe;
  import imm_ext_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  in_imm = '0;
  logic [1:0]  in_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_imm;
  logic [1:0]  count;

  int n_checks = 0;
  int n_pass   = 0;

  imm_extend_pipe dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_imm   (in_imm),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_imm  (out_imm),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Offer one immediate for exactly one edge; returns on the following negedge.
  task automatic push_imm(input logic [6:0] imm, input logic [1:0] mode);
    @(negedge clk);
    in_valid = 1'b1;
    in_imm   = imm;
    in_mode  = mode;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] exp;
    string       tag;
  } vec_t;

  vec_t vecs [4];

  initial begin
    vecs[0] = '{mode: 2'(SIGN),   exp: 16'hFFD5, tag: "sign_55"};
    vecs[1] = '{mode: 2'(ZERO),   exp: 16'h0055, tag: "zero_55"};
    vecs[2] = '{mode: 2'(UPPER),  exp: 16'hAA00, tag: "upper_55"};
    vecs[3] = '{mode: 2'(BRANCH), exp: 16'hFFAA, tag: "branch_55"};

    // Reset state
    #1;
    check_val("rst_count", 32'(count), 0);
    check_val("rst_out_valid", 32'(out_valid), 0);
    check_val("rst_out_imm", 32'(out_imm), 0);
    check_val("rst_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    check_val("in_ready_before_edge", 32'(in_ready), 0);
    @(negedge clk);
    check_val("in_ready_after_edge", 32'(in_ready), 1);

    // Extension modes, one-cycle latency from empty
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      push_imm(7'b1010101, vecs[i].mode);
      check_val({vecs[i].tag, "_valid"}, 32'(out_valid), 1);
      check_val(vecs[i].tag, 32'(out_imm), 32'(vecs[i].exp));
    end
    @(negedge clk);
    check_val("drained_count", 32'(count), 0);

    // Fill to full with downstream stalled, then drain in order
    out_ready = 1'b0;
    push_imm(7'b0001111, 2'(SIGN));
    push_imm(7'b0000001, 2'(SIGN));
    check_val("full_count", 32'(count), 2);
    check_val("full_in_ready", 32'(in_ready), 0);
    check_val("stall_head", 32'(out_imm), 32'h000F);
    @(negedge clk);
    check_val("stall_hold", 32'(out_imm), 32'h000F);
    out_ready = 1'b1;
    @(negedge clk);
    check_val("drain_second", 32'(out_imm), 32'h0001);
    check_val("drain_count", 32'(count), 1);
    @(negedge clk);
    check_val("drain_empty_valid", 32'(out_valid), 0);
    check_val("drain_empty_imm", 32'(out_imm), 0);

    // Simultaneous push and pop at count=1
    out_ready = 1'b0;
    push_imm(7'h03, 2'(ZERO));
    check_val("pp_pre_count", 32'(count), 1);
    in_valid  = 1'b1;
    in_imm    = 7'h04;
    in_mode   = 2'(ZERO);
    out_ready = 1'b1;
    check_val("pp_head_old", 32'(out_imm), 32'h0003);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_val("pp_count", 32'(count), 1);
    check_val("pp_head_new", 32'(out_imm), 32'h0004);
    out_ready = 1'b1;
    @(negedge clk);
    check_val("pp_drained", 32'(count), 0);

    // Flush at count=2 with a pop requested in the same cycle
    out_ready = 1'b0;
    push_imm(7'h11, 2'(ZERO));
    push_imm(7'h12, 2'(ZERO));
    check_val("fl_pre_count", 32'(count), 2);
    flush     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_imm    = 7'h13;
    check_val("fl_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    check_val("fl_count", 32'(count), 0);
    check_val("fl_out_valid", 32'(out_valid), 0);
    push_imm(7'h7F, 2'(SIGN));
    check_val("post_flush_push", 32'(out_imm), 32'hFFFF);
    @(negedge clk);

    // Asynchronous reset with an entry held
    out_ready = 1'b0;
    push_imm(7'h2A, 2'(ZERO));
    check_val("ar_pre_count", 32'(count), 1);
    #2;
    rst = 1'b1;
    #1;
    check_val("ar_out_valid", 32'(out_valid), 0);
    check_val("ar_count", 32'(count), 0);
    check_val("ar_out_imm", 32'(out_imm), 0);
    check_val("ar_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("ar_recover_ready", 32'(in_ready), 1);
    check_val("ar_recover_valid", 32'(out_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 The block SHALL have parameter IMM_W, default 7, raw immediate width.
REQ-002 The block SHALL have parameter OUT_W, default 16, extended result width; OUT_W >= IMM_W.
REQ-003 The block SHALL have parameter DEPTH, default 2, output buffer entries; DEPTH >= 1.
REQ-004 The block SHALL have parameter UPPER_SHAMT, default 9, left-shift amount for mode UPPER.
REQ-005 The block SHALL have parameter TAG_W, default 4, sideband tag width; used only when IMM_EXT_TAG_EN is defined.
REQ-006 The block SHALL have one clock and an asynchronous, active-high reset; both ports are listed first.
REQ-007 The block SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-008 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-009 The block SHALL have port flush, input, 1 bit, synchronous buffer clear.
REQ-010 The block SHALL have port in_valid, input, 1 bit, upstream offers an immediate.
REQ-011 The block SHALL have port in_ready, output, 1 bit, block accepts this cycle.
REQ-012 The block SHALL have port in_imm, input, IMM_W bits, raw immediate field.
REQ-013 The block SHALL have port in_mode, input, 2 bits, extension mode.
REQ-014 The block SHALL have port in_tag, input, TAG_W bits, sideband tag; present only with IMM_EXT_TAG_EN.
REQ-015 The block SHALL have port out_valid, output, 1 bit, head entry valid.
REQ-016 The block SHALL have port out_ready, input, 1 bit, downstream consumes head.
REQ-017 The block SHALL have port out_imm, output, OUT_W bits, extended immediate.
REQ-018 The block SHALL have port out_tag, output, TAG_W bits, tag of head entry; present only with IMM_EXT_TAG_EN.
REQ-019 The block SHALL have port count, output, $clog2(DEPTH+1) bits, occupied entries.

Function
REQ-020 Mode 0 (ZERO) SHALL zero-extend in_imm to OUT_W.
REQ-021 Mode 1 (SIGN) SHALL replicate in_imm[IMM_W-1] into the upper OUT_W-IMM_W bits.
REQ-022 Mode 2 (UPPER) SHALL zero-extend, then shift left by UPPER_SHAMT, discarding bits above OUT_W-1.
REQ-023 Mode 3 (BRANCH) SHALL sign-extend, then shift left by 1, discarding bit OUT_W.
REQ-024 A transfer SHALL occur on a rising edge where in_valid and in_ready are both 1; the result is computed in that cycle and written into the buffer tail.
REQ-025 The result SHALL appear on out_imm with out_valid=1 exactly one cycle after acceptance when the buffer was empty.
REQ-026 in_ready SHALL equal (count != DEPTH) and not flush; it SHALL have no combinational dependence on out_ready.
REQ-027 A pop SHALL occur on an edge where out_valid and out_ready are both 1; entries leave in acceptance order.
REQ-028 A simultaneous push and pop SHALL leave count unchanged.
REQ-029 When full, a pop in that cycle SHALL NOT enable a push in that same cycle.
REQ-030 out_imm and out_tag SHALL hold stable while out_valid=1 and out_ready=0.
REQ-031 Buffer pointers SHALL wrap from DEPTH-1 to 0.
REQ-032 flush=1 SHALL empty the buffer at the next edge; any pop in that cycle is discarded; no push occurs.

Reset
REQ-033 rst=1 SHALL immediately force count=0, out_valid=0, pointers=0, out_imm=0, out_tag=0.
REQ-034 in_ready SHALL be 0 while rst=1 and 1 from the first edge after deassertion.
REQ-035 Reset asserted mid-transfer SHALL drop all buffered entries without producing a pop.

Configuration
REQ-036 With macro IMM_EXT_TAG_EN defined, in_tag/out_tag SHALL exist, and each tag SHALL travel with its immediate through the buffer.
REQ-037 Without IMM_EXT_TAG_EN, the tag ports and tag storage SHALL be absent; all other behaviour is identical.

Structure
REQ-038 Package imm_ext_pkg SHALL hold the mode enum (ZERO, SIGN, UPPER, BRANCH) and the mode-width constant.
REQ-039 Buffer storage and pointers SHALL live in sub-module imm_ext_fifo; extension logic stays in the top module.

Verification
REQ-040 in_imm=7'b1010101 in mode SIGN -> out_imm=16'hFFD5 one cycle later; in mode ZERO -> 16'h0055.
REQ-041 in_imm=7'b1010101 in mode UPPER -> 16'hAA00; in mode BRANCH -> 16'hFFAA.
REQ-042 Issue 7'b0001111 then 7'b0000001 in mode SIGN with out_ready=0 -> count=2, in_ready=0; then out_ready=1 -> 16'h000F, then 16'h0001, in order.
REQ-043 Push and pop in the same cycle at count=1 -> count stays 1 and the output order is preserved.
REQ-044 flush at count=2 -> count=0 and out_valid=0 at the next edge, with no pop observed.
REQ-045 rst asserted with count=1 -> out_valid=0 immediately, before any clock edge.
